instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Program buffer and issue stage that sits directly upstream of the 8-bit CPU core and drives its two instruction bytes. A host loads up to DEPTH 16-bit instruction words while idle, then pulses `start`. The block replays the stored words to the core one per clock, and optionally repeats the program. When no program is running it drives a NOP so the core holds state.

## Interface
Parameters:
- DEPTH, 16, number of 16-bit instruction words stored; power of two
- AW, 4, pointer width, log2(DEPTH)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- load_valid  in  1  host offers `load_word` this cycle
- load_word  in  16  [15:8] opcode/R1 byte, [7:0] R2/R3 or immediate byte
- load_ready  out  1  word accepted when `load_valid && load_ready`
- clear  in  1  discard stored program (IDLE only)
- start  in  1  begin replay (IDLE only)
- stop  in  1  abort replay (RUN only)
- loop_cnt  in  8  extra passes; present only with SEQ_LOOP_EN
- inst_hi  out  8  to core `ui_in`
- inst_lo  out  8  to core `uio_in`
- inst_valid  out  1  `inst_hi`/`inst_lo` carry a program word this cycle
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after the final word of the final pass
- count  out  AW+1  number of stored words, 0..DEPTH

## Operation
- States: IDLE, RUN, DONE. Reset and rst_n low force IDLE with the following values:
  - count=0 and pointers=0.
  - inst_hi=8'h40 (NOP opcode 4'b0100, R1=0) and inst_lo=8'h00.
  - inst_valid=0, busy=0, done=0.
- The program memory itself is not reset. count=0 makes its contents unreachable.
- IDLE:
  - load_ready = (count != DEPTH).
  - An accepted word is written at index count, and count increments.
  - load_valid while count==DEPTH is ignored.
  - clear sets count=0. If clear and an accepted load occur in the same cycle, clear wins and the word is dropped.
  - start with count>0 and no load accepted that cycle moves to RUN with rd_ptr=0.
  - start with count==0, or in the same cycle as an accepted load, is ignored.
  - stop is ignored in IDLE.
- RUN:
  - load_ready=0. clear and start are ignored.
  - Each cycle the word at rd_ptr is registered onto inst_hi/inst_lo with inst_valid=1, and rd_ptr increments.
  - After the word at index count-1:
    - if passes_left>0: rd_ptr wraps to 0 and passes_left decrements, with no bubble cycle;
    - otherwise the state goes to DONE.
  - stop goes to IDLE next cycle. Outputs return to NOP with valid=0. done does not pulse. The program and count are retained.
  - stop takes priority over end-of-program in the same cycle.
- DONE: lasts exactly one cycle. done=1, outputs are NOP, inst_valid=0. Next state is IDLE, with the program retained for re-start.
- All outputs are registered. No combinational path exists from inputs to outputs except `load_ready`, which is a decode of registered state only.

## Timing
- start sampled at edge T. Word 0 is visible on the outputs during cycle T+1. Word k is visible during cycle T+1+k.
- Single pass of N words: inst_valid is high for cycles T+1..T+N. done is high in cycle T+N+1. IDLE from T+N+2, when start is accepted again.
- With P passes, inst_valid is high for N·P contiguous cycles.
- Load throughput: one word per cycle; back-to-back loads are allowed.
- The core consumes one instruction per clock. The sequencer never stalls and has no backpressure from the core.
- rst_n low during RUN: on the next edge all outputs take their reset values and count=0. No done pulse.

## Configuration
- Macro SEQ_LOOP_EN.
  - Defined: `loop_cnt` port exists and is sampled on the accepted start edge. The program plays loop_cnt+1 times back-to-back. loop_cnt=0 gives a single pass and 255 gives 256 passes. passes_left is 8-bit.
  - Undefined: port and counter are removed and every start plays exactly once.

## Structure
- Shared package `cpu_ext_pkg` holds:
  - the opcode constants shared with the core (MVR, LDB, STB, RDS, NOP=4'b0100, ALU ops);
  - the state enum {IDLE, RUN, DONE};
  - the NOP instruction word 16'h4000.
- One sub-module, `seq_prog_mem`: DEPTH×16 register array with one synchronous write port and one asynchronous read port indexed by rd_ptr. The parent keeps the FSM, counters and output registers.

## Test plan
- Reset: hold rst_n low 2 cycles → inst_hi=0x40, inst_lo=0x00, inst_valid=0, busy=0, done=0, count=0, load_ready=1.
- Load 0x1305, 0x1407, 0xB345, then start at T → outputs 13/05 at T+1, 14/07 at T+2, B3/45 at T+3. done at T+4 only. count stays 3. A second start replays the identical sequence.
- Load 16 words → load_ready=0 once count=16. A 17th load_valid is ignored and count stays 16. clear → count=0 and load_ready=1.
- Start a 4-word program, assert stop during the cycle word 1 is shown → next cycle NOP with valid=0, busy=0, no done. A restart begins again at word 0.
- start with count=0 → stays IDLE with no valid and no done. Separately, rst_n low mid-RUN → all outputs at reset values the next cycle and count=0.
- SEQ_LOOP_EN, words A=0x1101, B=0x1202, loop_cnt=2 → 6 contiguous valid cycles A,B,A,B,A,B, then done for one cycle.

Source files
------------

// File: rtl/cpu_ext_pkg.sv
// Shared definitions for the CPU core and its instruction sequencer.
// Holds the core opcode constants, the sequencer state enum and the NOP word.
package cpu_ext_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PASS_W = 8;

  // Core opcodes (upper nibble of the high instruction byte)
  localparam logic [3:0] OP_MVR = 4'b0000;
  localparam logic [3:0] OP_LDB = 4'b0001;
  localparam logic [3:0] OP_STB = 4'b0010;
  localparam logic [3:0] OP_RDS = 4'b0011;
  localparam logic [3:0] OP_NOP = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_XOR = 4'b1100;

  // NOP with R1=0; keeps the core holding its state
  localparam logic [WORD_W-1:0] NOP_WORD = 16'h4000;
  localparam logic [BYTE_W-1:0] NOP_HI   = 8'h40;
  localparam logic [BYTE_W-1:0] NOP_LO   = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Host/core-facing bundle of the instruction sequencer.
// master: host side (drives load/control, observes issue outputs).
// slave : sequencer side.
// loop_cnt exists only when SEQ_LOOP_EN is defined.
interface instr_sequencer_if #(
  parameter int unsigned AW = 4
);
  logic        load_valid;
  logic [15:0] load_word;
  logic        load_ready;
  logic        clear;
  logic        start;
  logic        stop;
`ifdef SEQ_LOOP_EN
  logic [7:0]  loop_cnt;
`endif
  logic [7:0]  inst_hi;
  logic [7:0]  inst_lo;
  logic        inst_valid;
  logic        busy;
  logic        done;
  logic [AW:0] count;

  modport master (
`ifdef SEQ_LOOP_EN
    output loop_cnt,
`endif
    output load_valid, load_word, clear, start, stop,
    input  load_ready, inst_hi, inst_lo, inst_valid, busy, done, count
  );

  modport slave (
`ifdef SEQ_LOOP_EN
    input  loop_cnt,
`endif
    input  load_valid, load_word, clear, start, stop,
    output load_ready, inst_hi, inst_lo, inst_valid, busy, done, count
  );

endinterface

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x 16 register array, one synchronous write port,
// one asynchronous read port. Contents are intentionally not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module seq_prog_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program buffer and issue stage feeding the 8-bit CPU core.
// Host loads up to DEPTH words while idle, pulses start, and the words are
// replayed one per clock on inst_hi/inst_lo; NOP is driven otherwise.
// Ports: clk, rst_n (synchronous, active-low), bus (instr_sequencer_if.slave).
// Macro SEQ_LOOP_EN adds loop_cnt: program plays loop_cnt+1 passes.
module instr_sequencer
  import cpu_ext_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_sequencer_if.slave  bus
);

  localparam int unsigned CW = AW + 1;

  seq_state_e         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [BYTE_W-1:0]  hi_q, hi_d;
  logic [BYTE_W-1:0]  lo_q, lo_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SEQ_LOOP_EN
  logic [PASS_W-1:0]  passes_q, passes_d;
`endif

  logic               load_ready_c;
  logic               load_acc;
  logic               mem_we;
  logic               end_of_pass;
  logic               more_passes;
  logic [AW-1:0]      rd_addr;
  logic [WORD_W-1:0]  rd_word;

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (count_q[AW-1:0]),
    .wdata (bus.load_word),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // Ready is a decode of registered state only
  assign load_ready_c = (state_q == IDLE) && (count_q != CW'(DEPTH));
  assign load_acc     = bus.load_valid && load_ready_c;

  // rd_ptr counts words already issued in this pass; equal to count means the
  // last word is on the outputs now
  assign end_of_pass = (rd_ptr_q == count_q);

`ifdef SEQ_LOOP_EN
  assign more_passes = (passes_q != '0);
`else
  assign more_passes = 1'b0;
`endif

  // Word 0 is fetched on start and on pass wrap; otherwise the next word
  assign rd_addr = (state_q == RUN && !end_of_pass) ? rd_ptr_q[AW-1:0] : '0;

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    hi_d     = NOP_HI;
    lo_d     = NOP_LO;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    mem_we   = 1'b0;
`ifdef SEQ_LOOP_EN
    passes_d = passes_q;
`endif

    unique case (state_q)
      IDLE: begin
        // clear beats load; an accepted load blocks start in the same cycle
        if (bus.clear) begin
          count_d = '0;
        end else if (load_acc) begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
        end else if (bus.start && (count_q != '0)) begin
          state_d      = RUN;
          {hi_d, lo_d} = rd_word;
          valid_d      = 1'b1;
          rd_ptr_d     = CW'(1);
`ifdef SEQ_LOOP_EN
          passes_d     = bus.loop_cnt;
`endif
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_d  = IDLE;
          rd_ptr_d = '0;
        end else if (end_of_pass) begin
          if (more_passes) begin
            {hi_d, lo_d} = rd_word;
            valid_d      = 1'b1;
            rd_ptr_d     = CW'(1);
`ifdef SEQ_LOOP_EN
            passes_d     = passes_q - PASS_W'(1);
`endif
          end else begin
            state_d  = DONE;
            done_d   = 1'b1;
            rd_ptr_d = '0;
          end
        end else begin
          {hi_d, lo_d} = rd_word;
          valid_d      = 1'b1;
          rd_ptr_d     = rd_ptr_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        rd_ptr_d = '0;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      hi_q     <= NOP_HI;
      lo_q     <= NOP_LO;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_LOOP_EN
      passes_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SEQ_LOOP_EN
      passes_q <= passes_d;
`endif
    end
  end

  assign bus.load_ready = load_ready_c;
  assign bus.inst_hi    = hi_q;
  assign bus.inst_lo    = lo_q;
  assign bus.inst_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based
// reference model of the program replay behaviour.
module tb_instr_sequencer;
  import cpu_ext_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_sequencer_if #(.AW(AW)) bus ();

  instr_sequencer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] cur_lc;

  // Reference model: stored program, word count, and a playlist of what the
  // outputs will show on each coming cycle (a done marker ends the list)
  typedef struct {
    bit          is_done;
    logic [15:0] w;
  } ent_t;

  logic [15:0] m_prog [DEPTH];
  int          m_cnt;
  ent_t        m_q [$];
  logic [7:0]  m_hi, m_lo;
  bit          m_valid, m_done;

  function automatic void show_nop();
    m_hi = 8'h40; m_lo = 8'h00; m_valid = 1'b0; m_done = 1'b0;
  endfunction

  function automatic void pop_show();
    ent_t e;
    e = m_q.pop_front();
    if (e.is_done) begin
      show_nop();
      m_done = 1'b1;
    end else begin
      m_hi = e.w[15:8]; m_lo = e.w[7:0]; m_valid = 1'b1; m_done = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    int passes;
    ent_t e;
    if (!rst_n) begin
      m_q.delete(); m_cnt = 0; show_nop();
    end else if (m_valid) begin
      if (bus.stop) begin
        m_q.delete(); show_nop();
      end else begin
        pop_show();
      end
    end else if (m_done) begin
      show_nop();
    end else begin
      if (bus.clear) begin
        m_cnt = 0;
      end else if (bus.load_valid && m_cnt < DEPTH) begin
        m_prog[m_cnt] = bus.load_word;
        m_cnt++;
      end else if (bus.start && m_cnt > 0) begin
        passes = 1 + (LOOP_EN ? int'(cur_lc) : 0);
        for (int p = 0; p < passes; p++) begin
          for (int k = 0; k < m_cnt; k++) begin
            e.is_done = 1'b0; e.w = m_prog[k];
            m_q.push_back(e);
          end
        end
        e.is_done = 1'b1; e.w = '0;
        m_q.push_back(e);
        pop_show();
      end
    end
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void compare_model();
    bit idle;
    idle = !m_valid && !m_done;
    chk("model inst_hi",    32'(bus.inst_hi),    32'(m_hi));
    chk("model inst_lo",    32'(bus.inst_lo),    32'(m_lo));
    chk("model inst_valid", 32'(bus.inst_valid), 32'(m_valid));
    chk("model busy",       32'(bus.busy),       32'(m_valid));
    chk("model done",       32'(bus.done),       32'(m_done));
    chk("model count",      32'(bus.count),      32'(m_cnt));
    chk("model load_ready", 32'(bus.load_ready), 32'(idle && (m_cnt < DEPTH)));
  endfunction

  task automatic set_in(input bit r, input bit lv, input logic [15:0] w,
                        input bit cl, input bit st, input bit sp,
                        input logic [7:0] lc);
    rst_n          = r;
    bus.load_valid = lv;
    bus.load_word  = w;
    bus.clear      = cl;
    bus.start      = st;
    bus.stop       = sp;
    cur_lc         = lc;
`ifdef SEQ_LOOP_EN
    bus.loop_cnt   = lc;
`endif
  endtask

  task automatic idle_in();
    set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic load_word_cycle(input logic [15:0] w);
    set_in(1'b1, 1'b1, w, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
  endtask

  // Directed vector table: inputs before an edge, outputs expected after it
  typedef struct {
    bit         rst;
    bit         lv;
    logic [15:0] w;
    bit         cl;
    bit         st;
    bit         sp;
    logic [7:0] e_hi;
    logic [7:0] e_lo;
    bit         e_v;
    bit         e_b;
    bit         e_d;
    logic [4:0] e_cnt;
    bit         e_rdy;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{0, 0, 16'h0000, 0, 0, 0, 8'h40, 8'h00, 0, 0, 0, 5'd0, 1};
    vecs[1]  = '{0, 0, 16'h0000, 0, 0, 0, 8'h40, 8'h00, 0, 0, 0, 5'd0, 1};
    vecs[2]  = '{1, 1, 16'h1305, 0, 0, 0, 8'h40, 8'h00, 0, 0, 0, 5'd1, 1};
    vecs[3]  = '{1, 1, 16'h1407, 0, 0, 0, 8'h40, 8'h00, 0, 0, 0, 5'd2, 1};
    vecs[4]  = '{1, 1, 16'hB345, 0, 0, 0, 8'h40, 8'h00, 0, 0, 0, 5'd3, 1};
    vecs[5]  = '{1, 0, 16'h0000, 0, 1, 0, 8'h13, 8'h05, 1, 1, 0, 5'd3, 0};
    vecs[6]  = '{1, 0, 16'h0000, 0, 0, 0, 8'h14, 8'h07, 1, 1, 0, 5'd3, 0};
    vecs[7]  = '{1, 0, 16'h0000, 0, 0, 0, 8'hB3, 8'h45, 1, 1, 0, 5'd3, 0};
    vecs[8]  = '{1, 0, 16'h0000, 0, 0, 0, 8'h40, 8'h00, 0, 0, 1, 5'd3, 0};
    vecs[9]  = '{1, 0, 16'h0000, 0, 0, 0, 8'h40, 8'h00, 0, 0, 0, 5'd3, 1};
    vecs[10] = '{1, 0, 16'h0000, 0, 1, 0, 8'h13, 8'h05, 1, 1, 0, 5'd3, 0};
    vecs[11] = '{1, 0, 16'h0000, 0, 0, 0, 8'h14, 8'h07, 1, 1, 0, 5'd3, 0};
    vecs[12] = '{1, 0, 16'h0000, 0, 0, 0, 8'hB3, 8'h45, 1, 1, 0, 5'd3, 0};
    vecs[13] = '{1, 0, 16'h0000, 0, 0, 0, 8'h40, 8'h00, 0, 0, 1, 5'd3, 0};
    vecs[14] = '{1, 0, 16'h0000, 0, 0, 0, 8'h40, 8'h00, 0, 0, 0, 5'd3, 1};

    m_cnt = 0;
    show_nop();
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);

    // Table phase: reset, three-word load, two identical replays
    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].rst, vecs[i].lv, vecs[i].w, vecs[i].cl, vecs[i].st,
             vecs[i].sp, 8'd0);
      tick();
      chk($sformatf("vec%0d inst_hi", i),    32'(bus.inst_hi),    32'(vecs[i].e_hi));
      chk($sformatf("vec%0d inst_lo", i),    32'(bus.inst_lo),    32'(vecs[i].e_lo));
      chk($sformatf("vec%0d inst_valid", i), 32'(bus.inst_valid), 32'(vecs[i].e_v));
      chk($sformatf("vec%0d busy", i),       32'(bus.busy),       32'(vecs[i].e_b));
      chk($sformatf("vec%0d done", i),       32'(bus.done),       32'(vecs[i].e_d));
      chk($sformatf("vec%0d count", i),      32'(bus.count),      32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d load_ready", i), 32'(bus.load_ready), 32'(vecs[i].e_rdy));
    end

    // Fill to DEPTH, overflow attempt, then clear
    set_in(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0);
    tick();
    for (int i = 0; i < DEPTH; i++) load_word_cycle(16'(16'h2000 + i));
    chk("full count", 32'(bus.count), 32'd16);
    chk("full load_ready", 32'(bus.load_ready), 32'd0);
    load_word_cycle(16'hDEAD);
    chk("overflow count", 32'(bus.count), 32'd16);
    set_in(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 8'd0);
    tick();
    chk("clear count", 32'(bus.count), 32'd0);
    chk("clear load_ready", 32'(bus.load_ready), 32'd1);

    // Stop while word 1 is shown, then restart from word 0
    for (int i = 0; i < 4; i++) load_word_cycle(16'(16'h3100 + i));
    set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0);
    tick();
    idle_in();
    tick();
    chk("stop pre word1 hi", 32'(bus.inst_hi), 32'h31);
    chk("stop pre word1 lo", 32'(bus.inst_lo), 32'h01);
    set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd0);
    tick();
    chk("stop valid", 32'(bus.inst_valid), 32'd0);
    chk("stop busy", 32'(bus.busy), 32'd0);
    chk("stop done", 32'(bus.done), 32'd0);
    chk("stop hi nop", 32'(bus.inst_hi), 32'h40);
    idle_in();
    tick();
    chk("stop no done later", 32'(bus.done), 32'd0);
    chk("stop count kept", 32'(bus.count), 32'd4);
    set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0);
    tick();
    chk("restart word0 lo", 32'(bus.inst_lo), 32'h00);
    chk("restart valid", 32'(bus.inst_valid), 32'd1);
    idle_in();
    for (int i = 0; i < 6; i++) tick();

    // Start with empty program is ignored
    set_in(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0);
    tick();
    set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0);
    tick();
    chk("empty start valid", 32'(bus.inst_valid), 32'd0);
    chk("empty start busy", 32'(bus.busy), 32'd0);
    idle_in();
    tick();
    chk("empty start done", 32'(bus.done), 32'd0);

    // Reset in the middle of a run
    load_word_cycle(16'h5A5A);
    load_word_cycle(16'h6B6B);
    set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0);
    tick();
    chk("pre-reset valid", 32'(bus.inst_valid), 32'd1);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    chk("midrun reset hi", 32'(bus.inst_hi), 32'h40);
    chk("midrun reset valid", 32'(bus.inst_valid), 32'd0);
    chk("midrun reset count", 32'(bus.count), 32'd0);
    chk("midrun reset done", 32'(bus.done), 32'd0);
    idle_in();
    tick();
    chk("post-reset done", 32'(bus.done), 32'd0);

`ifdef SEQ_LOOP_EN
    // Three passes of a two-word program
    load_word_cycle(16'h1101);
    load_word_cycle(16'h1202);
    set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd2);
    for (int i = 0; i < 6; i++) begin
      tick();
      idle_in();
      chk($sformatf("loop%0d valid", i), 32'(bus.inst_valid), 32'd1);
      chk($sformatf("loop%0d hi", i), 32'(bus.inst_hi), (i % 2 == 0) ? 32'h11 : 32'h12);
    end
    tick();
    chk("loop done", 32'(bus.done), 32'd1);
    chk("loop done valid", 32'(bus.inst_valid), 32'd0);
    tick();
    chk("loop done once", 32'(bus.done), 32'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      bit r, lv, cl, st, sp;
      r  = ($urandom_range(63) != 0);
      lv = 1'($urandom_range(1));
      cl = ($urandom_range(19) == 0);
      st = !cl && ($urandom_range(5) == 0);
      sp = ($urandom_range(15) == 0);
      set_in(r, lv, 16'($urandom), cl, st, sp, 8'($urandom_range(3)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
